// File: rtl/led_pwm_pkg.sv
// Shared defaults and helpers for the LED PWM output stage.
package led_pwm_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N_CH  = 16;

    typedef logic [DEF_WIDTH-1:0] duty_t;

    // Terminal count of the period counter: a period spans 2^WIDTH-1 ticks.
    localparam int PWM_MAX = (1 << DEF_WIDTH) - 2;

    function automatic int pwm_tc(input int width);
        return (1 << width) - 2;
    endfunction

    function automatic int ch_width(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_if.sv
// Duty-write handshake between the brightness controller and the PWM stage.
interface led_pwm_if
    import led_pwm_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int CH_W = ch_width(N_CH);

    logic [WIDTH-1:0] duty_in;
    logic [CH_W-1:0]  duty_chan;
    logic             duty_bcast;
    logic             duty_valid;
    logic             duty_ready;

    modport master (
        output duty_in, duty_chan, duty_bcast, duty_valid,
        input  duty_ready
    );

    modport slave (
        input  duty_in, duty_chan, duty_bcast, duty_valid,
        output duty_ready
    );

endinterface

// File: rtl/led_pwm_tick.sv
// Prescaler: one tick enable every PRESCALE sys_clk cycles.
module led_pwm_tick #(
    parameter int PRESCALE = 1
) (
    input  logic sys_clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    always_comb begin
        pre_d = pre_q + PW'(1);
        if (pre_q == PRE_TC) pre_d = '0;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) pre_q <= '0;
        else        pre_q <= pre_d;
    end

    assign tick_o = (pre_q == PRE_TC);

endmodule

// File: rtl/led_pwm_driver.sv
// Multi-channel LED PWM stage: shadow duty registers committed to the active
// set only at period wrap, registered per-channel compare outputs.
module led_pwm_driver
    import led_pwm_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic           sys_clk,
    input  logic           rst_n,
    led_pwm_if.slave       duty_if,
    output logic [N_CH-1:0] led,
    output logic           period_start
);

    localparam int CH_W = ch_width(N_CH);
    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(pwm_tc(WIDTH));

    logic             tick;
    logic             wrap;
    logic             wr_en;
    logic             ready_q;
    logic             ps_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [N_CH-1:0]  led_q;
    logic [N_CH-1:0]  led_d;
    logic [WIDTH-1:0] shadow_q [N_CH];
    logic [WIDTH-1:0] active_q [N_CH];

    led_pwm_tick #(.PRESCALE(PRESCALE)) u_tick (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .tick_o  (tick)
    );

    assign wr_en = duty_if.duty_valid & ready_q;
    assign wrap  = tick & (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (tick) cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
    end

    always_comb begin
        led_d = '0;
        for (int i = 0; i < N_CH; i++) led_d[i] = (cnt_q < active_q[i]);
    end

    // Shadow writes and the commit share an edge; active takes the pre-write
    // shadow, so a colliding write lands one period later. Channel indices
    // beyond N_CH match no shadow and are silently dropped.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            ps_q    <= 1'b0;
            cnt_q   <= '0;
            led_q   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            ready_q <= 1'b1;
            ps_q    <= wrap;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            for (int i = 0; i < N_CH; i++) begin
                if (wr_en && (duty_if.duty_bcast || duty_if.duty_chan == CH_W'(i)))
                    shadow_q[i] <= duty_if.duty_in;
                if (wrap)
                    active_q[i] <= shadow_q[i];
            end
        end
    end

    assign duty_if.duty_ready = ready_q;
    assign led                = led_q;
    assign period_start       = ps_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Bench for led_pwm_driver: per-period high counts measured on the pins and
// compared against expectations queued when the duty writes are issued.
module tb_led_pwm_driver;
    import led_pwm_pkg::*;

    localparam int NCH = 16;

    typedef struct {
        string tag;
        int    ch;
        int    kind;   // 0 high count, 1 first high sample, 2 last high sample, 3 period length
        int    exp;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst1_n;
    logic            rst4_n;
    logic [NCH-1:0]  led1;
    logic [NCH-1:0]  led4;
    logic            ps1;
    logic            ps4;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   obs_hi    [NCH];
    int   obs_first [NCH];
    int   obs_last  [NCH];
    int   obs_len;

    led_pwm_if #(.N_CH(NCH), .WIDTH(DEF_WIDTH)) if1 ();
    led_pwm_if #(.N_CH(NCH), .WIDTH(DEF_WIDTH)) if4 ();

    led_pwm_driver #(.N_CH(NCH), .WIDTH(DEF_WIDTH), .PRESCALE(1)) dut1 (
        .sys_clk      (clk),
        .rst_n        (rst1_n),
        .duty_if      (if1.slave),
        .led          (led1),
        .period_start (ps1)
    );

    led_pwm_driver #(.N_CH(NCH), .WIDTH(DEF_WIDTH), .PRESCALE(4)) dut4 (
        .sys_clk      (clk),
        .rst_n        (rst4_n),
        .duty_if      (if4.slave),
        .led          (led4),
        .period_start (ps4)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int ch, input int kind, input int exp);
        exp_t e;
        e.tag  = tag;
        e.ch   = ch;
        e.kind = kind;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int sel, input int bcast, input int ch, input int val, input logic vld);
        if (sel == 0) begin
            if1.duty_bcast = 1'(bcast);
            if1.duty_chan  = 4'(ch);
            if1.duty_in    = 8'(val);
            if1.duty_valid = vld;
        end else begin
            if4.duty_bcast = 1'(bcast);
            if4.duty_chan  = 4'(ch);
            if4.duty_in    = 8'(val);
            if4.duty_valid = vld;
        end
    endtask

    task automatic write(input int sel, input int bcast, input int ch, input int val);
        @(negedge clk);
        drive(sel, bcast, ch, val, 1'b1);
        @(negedge clk);
        drive(sel, 0, 0, 0, 1'b0);
    endtask

    function automatic logic cur_ps(input int sel);
        return (sel == 0) ? ps1 : ps4;
    endfunction

    // Measures one full period starting at a period_start sample; optionally
    // issues a single write at sample wr_at (sample c follows the c-th edge
    // after the commit, so wr_at = period-1 collides with the next commit).
    task automatic measure(input int sel, input int wr_at, input int wr_ch, input int wr_val);
        int             guard;
        logic [NCH-1:0] lv;
        logic           ps;
        for (int i = 0; i < NCH; i++) begin
            obs_hi[i]    = 0;
            obs_first[i] = 0;
            obs_last[i]  = 0;
        end
        obs_len = 0;
        guard   = 0;
        while (!cur_ps(sel) && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (!cur_ps(sel)) begin
            check_val("wait_period_start", 0, 1);
            return;
        end
        for (int c = 1; c <= 3000; c++) begin
            @(negedge clk);
            lv = (sel == 0) ? led1 : led4;
            ps = cur_ps(sel);
            for (int i = 0; i < NCH; i++) begin
                if (lv[i]) begin
                    obs_hi[i]++;
                    if (obs_first[i] == 0) obs_first[i] = c;
                    obs_last[i] = c;
                end
            end
            if (c == wr_at)     drive(sel, 0, wr_ch, wr_val, 1'b1);
            if (c == wr_at + 1) drive(sel, 0, 0, 0, 1'b0);
            if (ps) begin
                obs_len = c;
                break;
            end
        end
    endtask

    task automatic score();
        exp_t e;
        int   got;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                0:       got = obs_hi[e.ch];
                1:       got = obs_first[e.ch];
                2:       got = obs_last[e.ch];
                default: got = obs_len;
            endcase
            check_val($sformatf("%s_ch%0d_k%0d", e.tag, e.ch, e.kind), got, e.exp);
        end
    endtask

    initial begin
        int guard;
        rst1_n = 1'b0;
        rst4_n = 1'b0;
        drive(0, 0, 0, 0, 1'b0);
        drive(1, 0, 0, 0, 1'b0);

        // reset / idle
        repeat (10) @(negedge clk);
        check_val("rst_led", int'(led1), 0);
        check_val("rst_ps", int'(ps1), 0);
        check_val("rst_ready", int'(if1.duty_ready), 0);
        rst1_n = 1'b1;
        @(negedge clk);
        check_val("rel_ready", int'(if1.duty_ready), 1);
        check_val("rel_led", int'(led1), 0);
        check_val("rel_ps", int'(ps1), 0);

        // extremes
        write(0, 1, 0, 0);
        write(0, 0, 3, 255);
        push_exp("ext", 3, 0, 255);
        push_exp("ext", 3, 1, 1);
        push_exp("ext", 3, 2, 255);
        push_exp("ext", 0, 0, 0);
        push_exp("ext", 15, 0, 0);
        push_exp("ext", 0, 3, 255);
        measure(0, -10, 0, 0);
        score();

        // proportional
        write(0, 1, 0, 0);
        write(0, 0, 0, 128);
        write(0, 0, 1, 1);
        push_exp("prop", 0, 0, 128);
        push_exp("prop", 0, 2, 128);
        push_exp("prop", 1, 0, 1);
        push_exp("prop", 1, 1, 1);
        push_exp("prop", 3, 0, 0);
        push_exp("prop", 0, 3, 255);
        measure(0, -10, 0, 0);
        score();
        push_exp("prop2", 0, 0, 128);
        push_exp("prop2", 1, 0, 1);
        push_exp("prop2", 0, 3, 255);
        measure(0, -10, 0, 0);
        score();

        // mid-period update
        write(0, 0, 5, 200);
        push_exp("mid_a", 5, 0, 200);
        push_exp("mid_a", 0, 3, 255);
        measure(0, -10, 0, 0);
        score();
        push_exp("mid_b", 5, 0, 200);
        measure(0, 100, 5, 50);
        score();
        push_exp("mid_c", 5, 0, 50);
        push_exp("mid_c", 5, 1, 1);
        push_exp("mid_c", 5, 2, 50);
        push_exp("mid_c", 0, 0, 128);
        measure(0, -10, 0, 0);
        score();

        // last write wins
        write(0, 0, 5, 30);
        write(0, 0, 5, 60);
        push_exp("lww", 5, 0, 60);
        measure(0, -10, 0, 0);
        score();

        // boundary collision: write ch2 on the commit edge
        push_exp("coll_a", 2, 0, 0);
        push_exp("coll_a", 0, 3, 255);
        measure(0, 254, 2, 77);
        score();
        push_exp("coll_b", 2, 0, 0);
        push_exp("coll_b", 0, 3, 255);
        measure(0, -10, 0, 0);
        score();
        push_exp("coll_c", 2, 0, 77);
        push_exp("coll_c", 2, 2, 77);
        measure(0, -10, 0, 0);
        score();

        // prescale 4
        @(negedge clk);
        rst4_n = 1'b1;
        @(negedge clk);
        check_val("p4_ready", int'(if4.duty_ready), 1);
        write(1, 0, 7, 10);
        push_exp("p4", 7, 0, 40);
        push_exp("p4", 7, 1, 1);
        push_exp("p4", 7, 2, 40);
        push_exp("p4", 0, 0, 0);
        push_exp("p4", 0, 3, 1020);
        measure(1, -10, 0, 0);
        score();

        // async reset while ch7 is high
        guard = 0;
        while (!led4[7] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        repeat (5) @(negedge clk);
        check_val("p4_pre_rst_high", int'(led4[7]), 1);
        #2;
        rst4_n = 1'b0;
        #1;
        check_val("p4_async_led", int'(led4[7]), 0);
        check_val("p4_async_ready", int'(if4.duty_ready), 0);
        repeat (3) @(negedge clk);
        rst4_n = 1'b1;
        push_exp("p4_post", 7, 0, 0);
        push_exp("p4_post", 0, 3, 1020);
        measure(1, -10, 0, 0);
        score();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pwm_driver.md
# led_pwm_driver

Multi-channel LED PWM output stage that consumes 8-bit brightness values from the dimming/ramp controller and drives the board LEDs. It accepts duty updates per channel or broadcast via a valid/ready handshake and holds them in shadow registers. It commits all shadows to the active duty set only at a PWM period boundary, so no LED ever sees a glitched partial period. It sits directly downstream of the brightness controller and directly upstream of the LED pins.

## Interface

Parameters:
- N_CH, 16, number of LED channels.
- WIDTH, 8, duty resolution in bits.
- PRESCALE, 1, sys_clk cycles per PWM tick (≥1).

Ports:
- sys_clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is asynchronous and active-low.
- duty_in  in  WIDTH  duty value to load.
- duty_chan  in  $clog2(N_CH)  target channel, ignored when duty_bcast=1.
- duty_bcast  in  1  load duty_in into all channels.
- duty_valid  in  1  write request.
- duty_ready  out  1  write accepted when valid&ready.
- led  out  N_CH  registered PWM outputs.
- period_start  out  1  one-cycle pulse when the PWM counter wraps to 0 and the shadows commit.

## Operation

- Prescaler counts 0..PRESCALE-1 on sys_clk and asserts tick on the terminal count. With PRESCALE=1, tick is asserted every cycle.
- The period counter cnt advances on tick over 0..2^WIDTH-2 (255 states for WIDTH=8), then wraps to 0.
- Channel output is led[i] = (cnt < active[i]).
  - Duty 0: always off.
  - Duty 255: always on.
  - Duty d: on for exactly d ticks per period.
- Write handshake: when duty_valid & duty_ready, shadow[duty_chan] ← duty_in. If duty_bcast=1, every shadow gets duty_in.
- duty_ready is 1 whenever out of reset. No backpressure condition exists.
- Commit: on the tick that wraps cnt to 0, active[all] ← shadow[all] and period_start pulses.
- Simultaneous write and commit in the same cycle:
  - The commit takes the pre-write shadow value.
  - The new value commits at the following boundary.
- Out-of-range duty_chan (≥N_CH, when N_CH is not a power of 2): the write is accepted and discarded.
- Successive writes to one channel within a period: the last write wins.

## Timing

- Reset values: cnt=0, prescaler=0, shadow=0, active=0, led=0, period_start=0, duty_ready=0.
- Reset release:
  - duty_ready=1 from the first clock edge after rst_n rises.
  - The first tick occurs PRESCALE cycles later.
- Period length: (2^WIDTH−1)·PRESCALE sys_clk cycles.
- led is registered and reflects cnt/active one cycle after they update.
- Write-to-LED latency:
  - A write accepted at cycle t is visible on led one cycle after the next commit.
  - Worst case is one full period plus 1 cycle.
- period_start is high for exactly one sys_clk cycle per period, aligned with the commit edge.
- Asynchronous reset mid-period:
  - All state clears immediately.
  - led goes to 0 without waiting for a clock edge.
  - Pending shadow writes are lost.

## Structure

- Package led_pwm_pkg holds:
  - WIDTH and N_CH defaults.
  - duty_t (logic [WIDTH-1:0]).
  - PWM_MAX = 2^WIDTH−2, the terminal count.
- Sub-module led_pwm_tick holds the prescaler. It outputs the tick enable and takes sys_clk, rst_n and PRESCALE.
- The top level holds cnt, the shadow and active arrays, the handshake, and the per-channel compare.

## Test plan

- Reset/idle: hold rst_n=0 for 10 cycles, then release → led=0, period_start=0, duty_ready=1 the cycle after release.
- Extremes: broadcast duty 0, then 255 on ch3; sample one full period after commit → ch3 high 255/255 ticks, others high 0/255 ticks.
- Proportional duty, PRESCALE=1: ch0=128, ch1=1 → per 255-cycle period, ch0 high 128 cycles, ch1 high 1 cycle at cnt=0, period_start every 255 cycles.
- Mid-period update: ch5=200 committed, then write ch5=50 at cnt=100 → ch5 keeps the 200 pattern until the next period_start, then goes high for exactly 50 ticks.
- Boundary collision: assert a write ch2=77 in the same cycle as the commit tick → the current period uses the old value; 77 appears one period later.
- Prescale and reset: PRESCALE=4, duty 10 on ch7 → high for 40 cycles of a 1020-cycle period. Drop rst_n mid-high → led[7]=0 immediately; after release, ch7 stays 0 until rewritten.
